// File: rtl/cpu_ctrl_pkg.sv
// Shared control definitions for the 5-stage CPU: FSM states, register-zero and opcode constants.
// Combinational helper only; no latency, no backpressure.
package cpu_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN      = 2'd1,
    MEM_WAIT = 2'd2,
    HALT     = 2'd3
  } state_t;

  localparam logic [4:0] REG_ZERO = 5'd0;
  localparam logic [2:0] OP_BEQ   = 3'b110;

  // x0 is hardwired to zero, so a producer targeting it never creates a dependency
  function automatic logic reg_hit(input logic [4:0] rd,
                                   input logic [4:0] rs1,
                                   input logic [4:0] rs2,
                                   input logic       uses_rs2);
    return (rd != REG_ZERO) && ((rd == rs1) || (uses_rs2 && (rd == rs2)));
  endfunction

endpackage

// File: rtl/hazard_detect.sv
// Load-use and branch-operand match against the ID-stage sources.
// Purely combinational, zero latency; no backpressure of its own.
module hazard_detect
  import cpu_ctrl_pkg::*;
(
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       id_uses_rs2,
  input  logic       id_is_branch,
  input  logic [4:0] ex_rd,
  input  logic       ex_regwrite,
  input  logic       ex_memread,
  input  logic [4:0] mem_rd,
  input  logic       mem_memread,
  output logic       lu,
  output logic       br
);

  logic ex_hit;
  logic mem_hit;

  assign ex_hit  = reg_hit(ex_rd, id_rs1, id_rs2, id_uses_rs2);
  assign mem_hit = reg_hit(mem_rd, id_rs1, id_rs2, id_uses_rs2);

  assign lu = ex_memread && ex_hit;
  // beq compares in ID, so it must wait for any EX result and for a load still in MEM
  assign br = id_is_branch && ((ex_regwrite && ex_hit) || (mem_memread && mem_hit));

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer: Mealy enables/bubble/flush in the hazard cycle (0 latency);
// freezes every stage while a data-memory access waits for ack, halting stickily on timeout.
module pipeline_hazard_ctrl
  import cpu_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [4:0]       id_rs1_i,
  input  logic [4:0]       id_rs2_i,
  input  logic             id_uses_rs2_i,
  input  logic             id_is_branch_i,
  input  logic             id_branch_taken_i,
  input  logic [4:0]       ex_rd_i,
  input  logic             ex_regwrite_i,
  input  logic             ex_memread_i,
  input  logic [4:0]       mem_rd_i,
  input  logic             mem_memread_i,
  input  logic             mem_req_i,
  input  logic             mem_ack_i,
  output logic             pc_write_o,
  output logic             if_id_write_o,
  output logic             id_ex_write_o,
  output logic             ex_mem_write_o,
  output logic             mem_wb_write_o,
  output logic             if_flush_o,
  output logic             id_ex_bubble_o,
  output logic             halt_o,
  output logic [CNT_W-1:0] stall_cnt_o
);

  localparam int WW = $clog2(MEM_TIMEOUT + 1);

  state_t          state_q, state_nxt;
  logic [WW-1:0]   wait_cnt_q, wait_cnt_nxt, wait_inc;
  logic [CNT_W-1:0] stall_cnt_q;
  logic            halt_q;
  logic            lu, br, mw;
  logic [4:0]      wr_en;
  logic            bubble, flush;
  logic            stall_inc;

  hazard_detect u_hazard_detect (
    .id_rs1       (id_rs1_i),
    .id_rs2       (id_rs2_i),
    .id_uses_rs2  (id_uses_rs2_i),
    .id_is_branch (id_is_branch_i),
    .ex_rd        (ex_rd_i),
    .ex_regwrite  (ex_regwrite_i),
    .ex_memread   (ex_memread_i),
    .mem_rd       (mem_rd_i),
    .mem_memread  (mem_memread_i),
    .lu           (lu),
    .br           (br)
  );

  assign mw       = mem_req_i && !mem_ack_i;
  assign wait_inc = wait_cnt_q + WW'(1);

  // wr_en order: {pc, if_id, id_ex, ex_mem, mem_wb}
  always_comb begin
    wr_en        = 5'b00000;
    bubble       = 1'b1;
    flush        = 1'b0;
    state_nxt    = state_q;
    wait_cnt_nxt = wait_cnt_q;
    case (state_q)
      IDLE: begin
        wait_cnt_nxt = '0;
        if (start_i) state_nxt = RUN;
      end
      RUN, MEM_WAIT: begin
        if (mw) begin
          bubble       = 1'b0;
          wait_cnt_nxt = wait_inc;
          state_nxt    = (wait_inc >= WW'(MEM_TIMEOUT)) ? HALT : MEM_WAIT;
        end else begin
          state_nxt    = RUN;
          wait_cnt_nxt = '0;
          if (lu || br) begin
            wr_en  = 5'b00111;
          end else begin
            wr_en  = 5'b11111;
            bubble = 1'b0;
            flush  = id_branch_taken_i;
          end
        end
      end
      default: ;
    endcase
  end

  assign stall_inc = ((state_q == RUN) || (state_q == MEM_WAIT)) && !wr_en[4];

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q     <= IDLE;
      wait_cnt_q  <= '0;
      stall_cnt_q <= '0;
      halt_q      <= 1'b0;
    end else begin
      state_q    <= state_nxt;
      wait_cnt_q <= wait_cnt_nxt;
      if (stall_inc && (stall_cnt_q != {CNT_W{1'b1}}))
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      if (state_nxt == HALT)
        halt_q <= 1'b1;
    end
  end

  assign pc_write_o     = wr_en[4];
  assign if_id_write_o  = wr_en[3];
  assign id_ex_write_o  = wr_en[2];
  assign ex_mem_write_o = wr_en[1];
  assign mem_wb_write_o = wr_en[0];
  assign if_flush_o     = flush;
  assign id_ex_bubble_o = bubble;
  assign halt_o         = halt_q;
  assign stall_cnt_o    = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed stimulus pushes expected per-cycle controls into a queue; a monitor pops and compares.
module tb_pipeline_hazard_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        start_i;
  logic [4:0]  id_rs1_i, id_rs2_i, ex_rd_i, mem_rd_i;
  logic        id_uses_rs2_i, id_is_branch_i, id_branch_taken_i;
  logic        ex_regwrite_i, ex_memread_i, mem_memread_i, mem_req_i, mem_ack_i;
  logic        pc_write_o, if_id_write_o, id_ex_write_o, ex_mem_write_o, mem_wb_write_o;
  logic        if_flush_o, id_ex_bubble_o, halt_o;
  logic [15:0] stall_cnt_o;

  typedef struct packed {
    logic [4:0]  en;
    logic        fl;
    logic        bub;
    logic        hlt;
    logic [15:0] cnt;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    n_tests = 0;
  int    n_fail  = 0;

  always #5 clk_i = ~clk_i;

  pipeline_hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(16)) dut (
    .clk_i             (clk_i),
    .rst_i             (rst_i),
    .start_i           (start_i),
    .id_rs1_i          (id_rs1_i),
    .id_rs2_i          (id_rs2_i),
    .id_uses_rs2_i     (id_uses_rs2_i),
    .id_is_branch_i    (id_is_branch_i),
    .id_branch_taken_i (id_branch_taken_i),
    .ex_rd_i           (ex_rd_i),
    .ex_regwrite_i     (ex_regwrite_i),
    .ex_memread_i      (ex_memread_i),
    .mem_rd_i          (mem_rd_i),
    .mem_memread_i     (mem_memread_i),
    .mem_req_i         (mem_req_i),
    .mem_ack_i         (mem_ack_i),
    .pc_write_o        (pc_write_o),
    .if_id_write_o     (if_id_write_o),
    .id_ex_write_o     (id_ex_write_o),
    .ex_mem_write_o    (ex_mem_write_o),
    .mem_wb_write_o    (mem_wb_write_o),
    .if_flush_o        (if_flush_o),
    .id_ex_bubble_o    (id_ex_bubble_o),
    .halt_o            (halt_o),
    .stall_cnt_o       (stall_cnt_o)
  );

  // Record the expectation for the current cycle, then move to just after the next edge
  task automatic cyc(input string nm, input logic [4:0] en, input logic fl,
                     input logic bub, input logic hlt, input int cnt);
    exp_t e;
    e.en  = en;
    e.fl  = fl;
    e.bub = bub;
    e.hlt = hlt;
    e.cnt = 16'(cnt);
    exp_q.push_back(e);
    name_q.push_back(nm);
    @(posedge clk_i);
    #1;
  endtask

  task automatic clr();
    start_i = 0; id_rs1_i = 0; id_rs2_i = 0; id_uses_rs2_i = 0;
    id_is_branch_i = 0; id_branch_taken_i = 0; ex_rd_i = 0; ex_regwrite_i = 0;
    ex_memread_i = 0; mem_rd_i = 0; mem_memread_i = 0; mem_req_i = 0; mem_ack_i = 0;
  endtask

  initial begin
    exp_t  e, a;
    string nm;
    forever begin
      @(negedge clk_i);
      if (exp_q.size() > 0) begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        a  = {pc_write_o, if_id_write_o, id_ex_write_o, ex_mem_write_o, mem_wb_write_o,
              if_flush_o, id_ex_bubble_o, halt_o, stall_cnt_o};
        n_tests++;
        if (a !== e) begin
          n_fail++;
          $display("FAIL %s: got en=%b flush=%b bubble=%b halt=%b cnt=%0d, expected en=%b flush=%b bubble=%b halt=%b cnt=%0d",
                   nm, a.en, a.fl, a.bub, a.hlt, a.cnt, e.en, e.fl, e.bub, e.hlt, e.cnt);
        end
      end
    end
  end

  initial begin
    rst_i = 0;
    clr();
    repeat (2) @(posedge clk_i);
    #1;
    cyc("reset", 5'b00000, 0, 1, 0, 0);
    rst_i = 1; start_i = 1;
    cyc("idle_start", 5'b00000, 0, 1, 0, 0);
    start_i = 0;
    cyc("run", 5'b11111, 0, 0, 0, 0);

    ex_memread_i = 1; ex_rd_i = 5; id_rs1_i = 5;
    cyc("load_use", 5'b00111, 0, 1, 0, 0);
    clr();
    cyc("after_lu", 5'b11111, 0, 0, 0, 1);
    ex_memread_i = 1; ex_rd_i = 0; id_rs1_i = 0;
    cyc("lu_rd0", 5'b11111, 0, 0, 0, 1);
    clr();

    id_is_branch_i = 1; id_branch_taken_i = 1; id_uses_rs2_i = 1; id_rs1_i = 1; id_rs2_i = 2;
    cyc("br_taken", 5'b11111, 1, 0, 0, 1);
    ex_regwrite_i = 1; ex_rd_i = 7; id_rs2_i = 7;
    cyc("br_ex_alu", 5'b00111, 0, 1, 0, 1);
    ex_memread_i = 1;
    cyc("br_ex_load", 5'b00111, 0, 1, 0, 2);
    ex_regwrite_i = 0; ex_memread_i = 0; ex_rd_i = 0; mem_memread_i = 1; mem_rd_i = 7;
    cyc("br_mem_load", 5'b00111, 0, 1, 0, 3);
    mem_memread_i = 0; mem_rd_i = 0;
    cyc("br_resolved", 5'b11111, 1, 0, 0, 4);
    clr();

    mem_req_i = 1;
    cyc("mw1", 5'b00000, 0, 0, 0, 4);
    cyc("mw2", 5'b00000, 0, 0, 0, 5);
    cyc("mw3", 5'b00000, 0, 0, 0, 6);
    mem_ack_i = 1;
    cyc("mw_ack", 5'b11111, 0, 0, 0, 7);
    cyc("ack_same_cycle", 5'b11111, 0, 0, 0, 7);
    clr();

    mem_req_i = 1; ex_memread_i = 1; ex_rd_i = 5; id_rs1_i = 5;
    id_is_branch_i = 1; id_branch_taken_i = 1;
    cyc("mw_lu_br", 5'b00000, 0, 0, 0, 7);
    mem_ack_i = 1;
    cyc("ack_then_lu", 5'b00111, 0, 1, 0, 8);
    clr();
    cyc("run_again", 5'b11111, 0, 0, 0, 9);

    ex_memread_i = 1; ex_rd_i = 5; id_rs1_i = 5;
    rst_i = 0;
    cyc("reset_mid", 5'b00000, 0, 1, 0, 0);
    clr();
    rst_i = 1; start_i = 1;
    cyc("restart_idle", 5'b00000, 0, 1, 0, 0);
    start_i = 0;
    cyc("restart_run", 5'b11111, 0, 0, 0, 0);

    mem_req_i = 1;
    cyc("to1", 5'b00000, 0, 0, 0, 0);
    cyc("to2", 5'b00000, 0, 0, 0, 1);
    cyc("to3", 5'b00000, 0, 0, 0, 2);
    cyc("to4", 5'b00000, 0, 0, 0, 3);
    cyc("halt", 5'b00000, 0, 1, 1, 4);
    start_i = 1; mem_ack_i = 1;
    cyc("halt_start", 5'b00000, 0, 1, 1, 4);
    clr();
    rst_i = 0;
    cyc("halt_reset", 5'b00000, 0, 1, 0, 0);

    @(negedge clk_i);
    #1;
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Central stall/flush sequencer for the 5-stage pipelined CPU. It holds the pipeline idle until start, and detects load-use and branch-operand hazards against the ID-stage compare. It freezes all stages while a multi-cycle data-memory access waits for acknowledge, and it drives the write-enable, bubble and flush controls of PC and the four pipeline buffers. A sticky halt on memory timeout and a stall-cycle counter support debug.

## Interface
- MEM_TIMEOUT, 16: max consecutive un-acked memory-wait cycles before halt (≥2)
- CNT_W, 16: width of stall counter
- clk_i  in  1  clock, rising edge
- rst_i  in  1  reset, asynchronous, active-low
- start_i  in  1  begin execution (level, sampled)
- id_rs1_i / id_rs2_i  in  5 each  ID source registers
- id_uses_rs2_i  in  1  ID instruction reads rs2
- id_is_branch_i  in  1  ID holds beq
- id_branch_taken_i  in  1  ID beq compare true
- ex_rd_i  in  5  EX destination
- ex_regwrite_i / ex_memread_i  in  1 each  EX writes reg / is load
- mem_rd_i  in  5  MEM destination
- mem_memread_i  in  1  MEM is load
- mem_req_i / mem_ack_i  in  1 each  MEM data access pending / completed this cycle
- pc_write_o, if_id_write_o, id_ex_write_o, ex_mem_write_o, mem_wb_write_o  out  1 each  stage register enables
- if_flush_o  out  1  zero IF/ID instruction
- id_ex_bubble_o  out  1  load NOP into ID/EX
- halt_o  out  1  sticky timeout error
- stall_cnt_o  out  CNT_W  saturating count of non-RUN-advance cycles

## Operation
- States: IDLE, RUN, MEM_WAIT, HALT. Reset → IDLE.
- IDLE: all *_write_o=0, id_ex_bubble_o=1, if_flush_o=0. start_i=1 at edge → RUN.
- Hazard terms, all combinational, with rd=0 never matching:
  - lu = ex_memread_i && ex_rd_i hits (id_rs1_i, or id_rs2_i if id_uses_rs2_i)
  - br = id_is_branch_i && ((ex_regwrite_i && ex_rd_i hit) || (mem_memread_i && mem_rd_i hit))
  - mw = mem_req_i && !mem_ack_i
- Priority: mw > (lu|br) > taken branch.
- mw (RUN or MEM_WAIT): all *_write_o=0, id_ex_bubble_o=0, if_flush_o=0; state → MEM_WAIT.
- lu|br, no mw: pc_write_o=if_id_write_o=0; id_ex_bubble_o=1; the remaining enables are 1; if_flush_o=0 (a stalled branch is not taken yet).
- id_branch_taken_i, no stall: all enables 1, if_flush_o=1.
- Otherwise all enables 1, bubble 0, flush 0.
- MEM_WAIT: wait_cnt increments per mw cycle. mem_ack_i → RUN, with that cycle advancing normally (hazard terms evaluated). wait_cnt reaching MEM_TIMEOUT with no ack → HALT.
- HALT: outputs as IDLE plus halt_o=1; exit only by reset. start_i is ignored.
- stall_cnt_o increments every cycle in RUN/MEM_WAIT where pc_write_o=0, and saturates at all-ones.
- start_i deassert in RUN is ignored.

## Timing
- Control outputs are Mealy: valid in the same cycle as the hazard inputs, with no added latency.
- State, wait_cnt, stall_cnt and halt_o are registered.
- Load-use stall lasts exactly 1 cycle: the load advances to MEM and lu clears.
- Branch on EX-ALU producer: 1 stall. Branch on EX-load producer: 2 stalls, the lu/br cycle then the MEM-load cycle.
- mw with mem_ack_i asserted in the same cycle as mem_req_i gives zero wait cycles.
- Reset mid-operation clears everything immediately: state IDLE, counters 0, halt_o 0, enables 0, bubble 1.
- wait_cnt clears on entering RUN.

## Structure
- Shared package cpu_ctrl_pkg: state enum {IDLE,RUN,MEM_WAIT,HALT}, REG_ZERO=5'd0, and the opcode constant for beq (3'b110) used by the integrating CPU.
- One sub-module, hazard_detect: the combinational lu/br match logic.
- FSM, counters and output decode live in the top.

## Test plan
- Reset low, then start_i=1 for 1 cycle → IDLE one cycle later → RUN; pc_write_o=1; stall_cnt_o=0.
- ex_memread_i=1, ex_rd_i=5, id_rs1_i=5 → one cycle with pc_write_o=0, if_id_write_o=0, id_ex_bubble_o=1; stall_cnt_o=1. Same with ex_rd_i=0 → no stall.
- id_is_branch_i=1, id_branch_taken_i=1, no hazard → if_flush_o=1, all enables 1. With ex_regwrite_i=1, ex_rd_i=id_rs2_i=7 → stall, if_flush_o=0.
- mem_req_i=1, mem_ack_i=0 for 3 cycles, then ack → 3 cycles all enables 0, then advance; stall_cnt_o +3.
- MEM_TIMEOUT=4, mem_req_i held, no ack → HALT after 4 wait cycles, halt_o=1, enables 0. Asserting start_i has no effect; rst_i low clears halt_o.
- Simultaneous mw and lu and taken branch → freeze only (bubble 0, flush 0). After ack, lu stall is applied next.
